one_add_arbiter: RTL and testbench

Shares a single instance of the team's two-stage pipelined 32-bit adder (`one`) among NUM_REQ independent requesters. Each cycle the block selects at most one request by round-robin, issues its operands into the adder, and carries a requester tag alongside the adder's pipeline so each sum is returned with the identity of the requester that issued it. It sits between requester-side valid/ready channels and the adder. It owns all sequencing, fairness and in-flight bookkeeping for the shared datapath.

---
 rtl/one_add_arb_pkg.sv | 18 +
 rtl/one_add_arb_if.sv | 28 ++
 rtl/one.sv | 18 +
 rtl/rr_pick.sv | 31 +++
 rtl/one_add_arbiter.sv | 71 +++++++
 tb/tb_one_add_arbiter.sv | 223 ++++++++++++++++++++++
 6 files changed

// File: rtl/one_add_arb_pkg.sv
// Shared constants and types for the round-robin front end of the shared adder.
package one_add_arb_pkg;

    localparam int LATENCY  = 2;
    localparam int MAX_ID_W = 4;
    localparam int INFL_W   = $clog2(LATENCY + 1);

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Tag id is sized for the largest supported requester count.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/one_add_arb_if.sv
// Requester/response bundle between the requesters and the adder arbiter.
interface one_add_arb_if
    import one_add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
);
    logic                    hold;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*32-1:0]   req_x;
    logic [NUM_REQ*32-1:0]   req_y;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [31:0]             rsp_sum;
    logic [INFL_W-1:0]       inflight;
    logic [31:0]             issue_count;

    modport master (
        output hold, req_valid, req_x, req_y,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, inflight, issue_count
    );

    modport slave (
        input  hold, req_valid, req_x, req_y,
        output req_ready, rsp_valid, rsp_id, rsp_sum, inflight, issue_count
    );
endinterface

// File: rtl/one.sv
// Two-stage pipelined 32-bit adder: operands registered, then the sum registered.
module one (
    input  logic        clk,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    logic [31:0] a_q, b_q, sum_q;

    // No reset: the datapath carries no control state.
    always_ff @(posedge clk) begin
        a_q   <= a_i;
        b_q   <= b_i;
        sum_q <= a_q + b_q;
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);
    int j;

    // Scan lowest priority first so the highest-priority hit is written last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (en_i && req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
                any_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/one_add_arbiter.sv
// Round-robin sharing of one pipelined adder among NUM_REQ requesters, tagging results.
module one_add_arbiter
    import one_add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst_n,
    one_add_arb_if.slave bus
);
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gidx, sel;
    logic               issue;
    logic [31:0]        x_op, y_op;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [INFL_W-1:0]  inflight_q, inflight_d;
    logic [31:0]        issue_cnt_q, issue_cnt_d;
    tag_t               tag_q [LATENCY];

    // Grants are suppressed during reset as well as hold.
    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (!bus.hold && rst_n),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (issue)
    );

    assign bus.req_ready = gnt;

    // Idle cycles keep steering the last winner's operands; that result is untagged.
    assign sel  = issue ? gidx : rr_ptr_q;
    assign x_op = bus.req_x[{sel, 5'b0} +: 32];
    assign y_op = bus.req_y[{sel, 5'b0} +: 32];

    one u_add (
        .clk   (clk),
        .a_i   (x_op),
        .b_i   (y_op),
        .sum_o (bus.rsp_sum)
    );

    always_comb begin
        rr_ptr_d    = issue ? gidx : rr_ptr_q;
        inflight_d  = inflight_q + INFL_W'(issue) - INFL_W'(bus.rsp_valid);
        issue_cnt_d = issue_cnt_q + 32'(issue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            inflight_q  <= '0;
            issue_cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            issue_cnt_q <= issue_cnt_d;
            tag_q[0]    <= tag_t'{valid: issue, id: MAX_ID_W'(gidx)};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign bus.rsp_valid   = tag_q[LATENCY-1].valid;
    assign bus.rsp_id      = ID_W'(tag_q[LATENCY-1].id);
    assign bus.inflight    = inflight_q;
    assign bus.issue_count = issue_cnt_q;
endmodule

// File: tb/tb_one_add_arbiter.sv
// Directed bench for one_add_arbiter with a queue-based reference model.
module tb_one_add_arbiter;
    localparam int N = 4;

    logic clk, rst_n;
    one_add_arb_if #(.NUM_REQ(N)) bus ();

    one_add_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of results still owed, each with the cycle it must appear in.
    typedef struct {
        int          id;
        logic [31:0] sum;
        int          due;
    } ent_t;
    ent_t        owed[$];
    int          mptr = N - 1;
    logic [31:0] mcnt = 0;
    int          cyc  = 0;

    int          glog[$];
    int          rid[$];
    logic [31:0] rsum[$];

    always @(negedge clk) begin
        int          g;
        logic [N-1:0] exp_rdy;
        logic [31:0] xs, ys;
        if (!rst_n) begin
            owed.delete();
            mptr = N - 1;
            mcnt = 0;
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_inflight", 32'(bus.inflight), 32'd0);
            chk("rst_issue_count", bus.issue_count, 32'd0);
        end else begin
            chk("inflight", 32'(bus.inflight), 32'(owed.size()));
            chk("issue_count", bus.issue_count, mcnt);
            if (owed.size() > 0 && owed[0].due == cyc) begin
                chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("rsp_id", 32'(bus.rsp_id), 32'(owed[0].id));
                chk("rsp_sum", bus.rsp_sum, owed[0].sum);
                void'(owed.pop_front());
            end else begin
                chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
            end
            if (bus.rsp_valid) begin
                rid.push_back(int'(bus.rsp_id));
                rsum.push_back(bus.rsp_sum);
            end
            g = -1;
            for (int k = 1; k <= N; k++) begin
                if (bus.req_valid[(mptr + k) % N]) begin
                    g = (mptr + k) % N;
                    break;
                end
            end
            exp_rdy = '0;
            if (!bus.hold && g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            for (int i = 0; i < N; i++)
                if (bus.req_ready[i] && bus.req_valid[i]) glog.push_back(i);
            if (exp_rdy != '0) begin
                xs = bus.req_x[32*g +: 32];
                ys = bus.req_y[32*g +: 32];
                owed.push_back('{id: g, sum: xs + ys, due: cyc + 2});
                mptr = g;
                mcnt = mcnt + 1;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic setreq(input int i, input logic v, input logic [31:0] x, input logic [31:0] y);
        bus.req_valid[i]     = v;
        bus.req_x[32*i +: 32] = x;
        bus.req_y[32*i +: 32] = y;
    endtask

    task automatic clear_logs();
        glog.delete();
        rid.delete();
        rsum.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single request from requester 2.
        setreq(2, 1'b1, 32'd5, 32'd7);
        #1 chk("t1_ready", 32'(bus.req_ready), 32'h4);
        step();
        setreq(2, 1'b0, 32'd5, 32'd7);
        chk("t1_infl_a", 32'(bus.inflight), 32'd1);
        step();
        chk("t1_infl_b", 32'(bus.inflight), 32'd1);
        chk("t1_rsp_v", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(bus.rsp_id), 32'd2);
        chk("t1_rsp_sum", bus.rsp_sum, 32'd12);
        step();
        chk("t1_infl_c", 32'(bus.inflight), 32'd0);
        chk("t1_rsp_v0", 32'(bus.rsp_valid), 32'd0);

        // Four requesters, continuously valid, from a fresh pointer.
        pulse_reset();
        clear_logs();
        for (int i = 0; i < N; i++) setreq(i, 1'b1, 32'(i), 32'd100);
        repeat (8) step();
        bus.req_valid = '0;
        repeat (3) step();
        chk("t2_count", bus.issue_count, 32'd8);
        chk("t2_ngrant", 32'(glog.size()), 32'd8);
        chk("t2_nrsp", 32'(rsum.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("t2_grant", 32'(glog[i]), 32'(i % 4));
        for (int i = 0; i < 8 && i < rsum.size(); i++) chk("t2_sum", rsum[i], 32'(100 + i % 4));

        // Wrap-around sums.
        clear_logs();
        setreq(0, 1'b1, 32'hFFFF_FFFF, 32'd1);
        step();
        setreq(0, 1'b0, 32'd0, 32'd0);
        setreq(1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        step();
        setreq(1, 1'b0, 32'd0, 32'd0);
        repeat (3) step();
        chk("t3_nrsp", 32'(rsum.size()), 32'd2);
        if (rsum.size() == 2) begin
            chk("t3_sum_a", rsum[0], 32'd0);
            chk("t3_sum_b", rsum[1], 32'd0);
        end

        // Hold with requesters 1 and 3 pending; pointer sits at 1.
        clear_logs();
        setreq(1, 1'b1, 32'd10, 32'd1);
        setreq(3, 1'b1, 32'd30, 32'd3);
        repeat (2) step();
        bus.hold = 1'b1;
        #1 chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
        repeat (3) step();
        chk("t4_drained", 32'(bus.inflight), 32'd0);
        chk("t4_nrsp", 32'(rsum.size()), 32'd2);
        bus.hold = 1'b0;
        repeat (4) step();
        bus.req_valid = '0;
        repeat (3) step();
        chk("t4_ngrant", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk("t4_grant", 32'(glog[i]), (i % 2 == 0) ? 32'd3 : 32'd1);
        for (int i = 0; i < 6 && i < rsum.size(); i++)
            chk("t4_sum", rsum[i], (i % 2 == 0) ? 32'd33 : 32'd11);

        // Reset with two operations in flight.
        setreq(0, 1'b1, 32'd1, 32'd1);
        setreq(2, 1'b1, 32'd2, 32'd2);
        repeat (2) step();
        chk("t5_infl2", 32'(bus.inflight), 32'd2);
        bus.req_valid = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("t5_infl0", 32'(bus.inflight), 32'd0);
        chk("t5_count0", bus.issue_count, 32'd0);

        // Requester 1 abandons while requester 0 is served.
        clear_logs();
        setreq(0, 1'b1, 32'd1, 32'd2);
        setreq(1, 1'b1, 32'd9, 32'd9);
        #1 chk("t6_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = '0;
        repeat (4) step();
        chk("t6_ngrant", 32'(glog.size()), 32'd1);
        chk("t6_nrsp", 32'(rid.size()), 32'd1);
        if (rid.size() == 1) begin
            chk("t6_id", 32'(rid[0]), 32'd0);
            chk("t6_sum", rsum[0], 32'd3);
        end
        chk("t6_count", bus.issue_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
